// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers for the EX stage.
// Operands are latched on accept; the result is written to HI/LO when the latency counter expires.
module mult_div_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [CNT_W-1:0] count;
  logic [1:0]       opReg;   // only mult/multu/div/divu reach RUN
  logic [WIDTH-1:0] opA;
  logic [WIDTH-1:0] opB;

  logic             isSigned;
  logic             negA;
  logic             negB;
  logic [2*WIDTH-1:0] extA;
  logic [2*WIDTH-1:0] extB;
  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0] magA;
  logic [WIDTH-1:0] magB;
  logic [WIDTH-1:0] quotMag;
  logic [WIDTH-1:0] remMag;
  logic [WIDTH-1:0] resHi;
  logic [WIDTH-1:0] resLo;

  // Result datapath on the latched operands; signed divide works on magnitudes so
  // most-negative / -1 wraps to most-negative with zero remainder.
  always_comb begin
    isSigned = ~opReg[0];
    negA     = isSigned & opA[WIDTH-1];
    negB     = isSigned & opB[WIDTH-1];
    extA     = {{WIDTH{negA}}, opA};
    extB     = {{WIDTH{negB}}, opB};
    product  = extA * extB;
    magA     = negA ? (~opA + WIDTH'(1)) : opA;
    magB     = negB ? (~opB + WIDTH'(1)) : opB;
    quotMag  = '0;
    remMag   = '0;
    resHi    = product[2*WIDTH-1:WIDTH];
    resLo    = product[WIDTH-1:0];
    if (opReg[1]) begin
      if (opB == '0) begin
        resHi = opA;
        resLo = '1;
      end else begin
        quotMag = magA / magB;
        remMag  = magA % magB;
        resLo   = (negA ^ negB) ? (~quotMag + WIDTH'(1)) : quotMag;
        resHi   = negA ? (~remMag + WIDTH'(1)) : remMag;
      end
    end
  end

  // Control FSM, operand latches and HI/LO registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      count <= '0;
      opReg <= '0;
      opA   <= '0;
      opB   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (!op[2]) begin
              opA   <= a;
              opB   <= b;
              opReg <= op[1:0];
              count <= op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
              state <= RUN;
              busy  <= 1'b1;
            end else if (op[1:0] == 2'b00) begin
              hi <= a;
            end else if (op[1:0] == 2'b01) begin
              lo <= a;
            end
          end
        end
        RUN: begin
          count <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            hi    <= resHi;
            lo    <= resLo;
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
